aes_shift_rows_buf: RTL and testbench

- Byte-serial ShiftRows stage of the AES-128 datapath. It sits directly downstream of the byte-wide SubBytes stage and consumes its output one byte per cycle.
- Collects 16-byte AES states in column-major order (index i = r + 4c) in a ping-pong buffer.
- Replays each state byte-serially in ShiftRows (or InvShiftRows) order to the next stage (MixColumns / AddRoundKey).
- Sustains 1 byte/cycle: one bank loads while the other drains.

---
 rtl/aes_pkg.sv | 24 ++
 rtl/aes_state_bank.sv | 30 +++
 rtl/aes_shift_rows_buf.sv | 101 ++++++++++
 tb/tb_aes_shift_rows_buf.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and the ShiftRows byte-order tables.
package aes_pkg;

   localparam int AES_NB_BYTES = 16;

   typedef logic [7:0] aes_byte_t;
   typedef logic [3:0] aes_idx_t;

   // Source byte index for output position k (column-major state).
   localparam aes_idx_t SHIFT_ROWS_IDX [AES_NB_BYTES] = '{
      4'd0,  4'd5,  4'd10, 4'd15,
      4'd4,  4'd9,  4'd14, 4'd3,
      4'd8,  4'd13, 4'd2,  4'd7,
      4'd12, 4'd1,  4'd6,  4'd11
   };

   localparam aes_idx_t INV_SHIFT_ROWS_IDX [AES_NB_BYTES] = '{
      4'd0,  4'd13, 4'd10, 4'd7,
      4'd4,  4'd1,  4'd14, 4'd11,
      4'd8,  4'd5,  4'd2,  4'd15,
      4'd12, 4'd9,  4'd6,  4'd3
   };

endpackage

// File: rtl/aes_state_bank.sv
// One 16-byte AES state register file: one write port, one async read port.
module aes_state_bank
   import aes_pkg::*;
#(
   parameter int BYTE_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  aes_idx_t          widx,
   input  logic [BYTE_W-1:0] wdata,
   input  aes_idx_t          ridx,
   output logic [BYTE_W-1:0] rdata
);

   logic [BYTE_W-1:0] mem [AES_NB_BYTES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < AES_NB_BYTES; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[widx] <= wdata;
      end
   end

   assign rdata = mem[ridx];

endmodule

// File: rtl/aes_shift_rows_buf.sv
// Byte-serial ShiftRows: ping-pong collects column-major states,
// replays each in (Inv)ShiftRows order while the other bank fills.
module aes_shift_rows_buf
   import aes_pkg::*;
#(
   parameter int BYTE_W  = 8,
   parameter bit INVERSE = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [BYTE_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [BYTE_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_last
);

   logic [1:0]        full;
   logic              wr_bank;
   logic              rd_bank;
   aes_idx_t          wr_cnt;
   aes_idx_t          rd_cnt;
   aes_idx_t          src_idx;
   logic              in_fire;
   logic              out_fire;
   logic [1:0]        we;
   logic [BYTE_W-1:0] rdata0;
   logic [BYTE_W-1:0] rdata1;

   assign in_ready  = !full[wr_bank];
   assign out_valid = full[rd_bank];
   assign out_last  = out_valid && (rd_cnt == 4'd15);
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;

   assign src_idx = INVERSE ? INV_SHIFT_ROWS_IDX[rd_cnt]
                            : SHIFT_ROWS_IDX[rd_cnt];

   // Writes in a flush cycle are dropped.
   assign we[0] = in_fire && !flush && !wr_bank;
   assign we[1] = in_fire && !flush &&  wr_bank;

   aes_state_bank #(.BYTE_W(BYTE_W)) u_bank0 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[0]),
      .widx  (wr_cnt),
      .wdata (in_data),
      .ridx  (src_idx),
      .rdata (rdata0)
   );

   aes_state_bank #(.BYTE_W(BYTE_W)) u_bank1 (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (we[1]),
      .widx  (wr_cnt),
      .wdata (in_data),
      .ridx  (src_idx),
      .rdata (rdata1)
   );

   assign out_data = rd_bank ? rdata1 : rdata0;

   // A write only fills a non-full bank and a read only drains a
   // full one, so both full-bit updates always hit different bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
      end else if (flush) begin
         full    <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt  <= '0;
         rd_cnt  <= '0;
      end else begin
         if (in_fire) begin
            wr_cnt <= wr_cnt + 4'd1;
            if (wr_cnt == 4'd15) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
            end
         end
         if (out_fire) begin
            rd_cnt <= rd_cnt + 4'd1;
            if (rd_cnt == 4'd15) begin
               full[rd_bank] <= 1'b0;
               rd_bank       <= !rd_bank;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_shift_rows_buf.sv
// Directed bench: forward and inverse instances driven in lockstep,
// outputs checked against hand-written ShiftRows sequences.
module tb_aes_shift_rows_buf;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       flush;
   logic [7:0] in_data;
   logic       in_valid;
   logic       out_ready;

   logic       in_ready_f, out_valid_f, out_last_f;
   logic [7:0] out_data_f;
   logic       in_ready_i, out_valid_i, out_last_i;
   logic [7:0] out_data_i;

   int checks = 0;
   int errors = 0;

   logic [7:0] qf [$];
   logic [7:0] qi [$];
   logic [3:0] fwd [16];
   logic [3:0] inv [16];

   int cyc = 0;
   int pos = 0;
   int n_out = 0;
   int first_cyc = 0;
   int last_cyc = 0;
   bit first_seen = 1'b0;
   int st;
   int st_sum;
   logic [7:0] exp_f;
   logic [7:0] exp_i;

   always #5 clk = ~clk;

   aes_shift_rows_buf #(.BYTE_W(8), .INVERSE(1'b0)) dut_f (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready_f),
      .out_data  (out_data_f),
      .out_valid (out_valid_f),
      .out_ready (out_ready),
      .out_last  (out_last_f)
   );

   aes_shift_rows_buf #(.BYTE_W(8), .INVERSE(1'b1)) dut_i (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready_i),
      .out_data  (out_data_i),
      .out_valid (out_valid_i),
      .out_ready (out_ready),
      .out_last  (out_last_i)
   );

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_block(input logic [7:0] base);
      for (int k = 0; k < 16; k++) begin
         qf.push_back(base + {4'h0, fwd[k]});
         qi.push_back(base + {4'h0, inv[k]});
      end
   endtask

   // Check any output beat about to be taken, then advance one cycle.
   task automatic tick();
      chk("valid_match", out_valid_i, out_valid_f);
      if (out_valid_f && out_ready) begin
         if (qf.size() == 0 || qi.size() == 0) begin
            chk("extra_out", 32'(out_data_f), 32'hFFFF);
         end else begin
            exp_f = qf.pop_front();
            exp_i = qi.pop_front();
            chk("data_fwd", out_data_f, exp_f);
            chk("data_inv", out_data_i, exp_i);
         end
         chk("last_fwd", out_last_f, (pos == 15));
         chk("last_inv", out_last_i, (pos == 15));
         pos = (pos + 1) % 16;
         if (!first_seen) first_cyc = cyc;
         first_seen = 1'b1;
         last_cyc = cyc;
         n_out++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic feed(input logic [7:0] b, output int stalls);
      bit ok;
      in_valid = 1'b1;
      in_data  = b;
      stalls   = 0;
      forever begin
         ok = in_ready_f;
         tick();
         if (ok) break;
         stalls++;
         if (stalls > 200) begin
            chk("feed_timeout", stalls, 0);
            break;
         end
      end
   endtask

   task automatic drain(input int target);
      int guard;
      guard = 0;
      while (n_out < target && guard < 300) begin
         tick();
         guard++;
      end
      chk("drain_cnt", n_out, target);
   endtask

   initial begin
      fwd = '{4'd0, 4'd5, 4'd10, 4'd15, 4'd4, 4'd9, 4'd14, 4'd3,
              4'd8, 4'd13, 4'd2, 4'd7, 4'd12, 4'd1, 4'd6, 4'd11};
      inv = '{4'd0, 4'd13, 4'd10, 4'd7, 4'd4, 4'd1, 4'd14, 4'd11,
              4'd8, 4'd5, 4'd2, 4'd15, 4'd12, 4'd9, 4'd6, 4'd3};
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b1;
      #12;
      chk("rst_in_ready", in_ready_f, 1);
      chk("rst_out_valid", out_valid_f, 0);
      chk("rst_out_last", out_last_f, 0);
      chk("rst_out_data", out_data_f, 8'h00);
      chk("rst_in_ready_i", in_ready_i, 1);
      chk("rst_out_data_i", out_data_i, 8'h00);
      #5 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Single state, forward and inverse order, latency.
      push_block(8'h00);
      st_sum = 0;
      for (int k = 0; k < 16; k++) begin
         feed(8'(k), st);
         st_sum += st;
         if (k == 14) chk("lat_early", out_valid_f, 0);
      end
      in_valid = 1'b0;
      chk("lat_valid", out_valid_f, 1);
      chk("lat_stalls", st_sum, 0);
      drain(16);
      chk("one_contig", last_cyc - first_cyc, 15);
      chk("one_qempty", qf.size(), 0);
      chk("one_idle", out_valid_f, 0);

      // Four back-to-back states.
      n_out = 0;
      first_seen = 1'b0;
      push_block(8'h00);
      push_block(8'h10);
      push_block(8'h20);
      push_block(8'h30);
      st_sum = 0;
      for (int k = 0; k < 64; k++) begin
         feed(8'(k), st);
         st_sum += st;
      end
      in_valid = 1'b0;
      drain(64);
      chk("strm_stalls", st_sum, 0);
      chk("strm_contig", last_cyc - first_cyc, 63);
      chk("strm_qempty", qf.size(), 0);

      // Backpressure: both banks fill, then release.
      n_out = 0;
      out_ready = 1'b0;
      push_block(8'h40);
      push_block(8'h50);
      for (int k = 0; k < 32; k++) feed(8'h40 + 8'(k), st);
      in_data = 8'h60;
      chk("bp_in_ready", in_ready_f, 0);
      chk("bp_valid", out_valid_f, 1);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("bp_hold_data", out_data_f, 8'h40);
         chk("bp_hold_data_i", out_data_i, 8'h40);
         chk("bp_hold_valid", out_valid_f, 1);
         chk("bp_hold_ready", in_ready_f, 0);
      end
      out_ready = 1'b1;
      feed(8'h60, st);
      chk("bp_release", st, 16);
      for (int k = 1; k < 8; k++) feed(8'h60 + 8'(k), st);
      in_valid = 1'b0;
      drain(32);
      chk("bp_qempty", qf.size(), 0);
      chk("bp_idle", out_valid_f, 0);

      // Flush: partial bank plus the would-be completing byte.
      for (int k = 0; k < 7; k++) feed(8'h70 + 8'(k), st);
      in_valid = 1'b1;
      in_data  = 8'h77;
      flush    = 1'b1;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("fl_valid", out_valid_f, 0);
      chk("fl_ready", in_ready_f, 1);
      n_out = 0;
      pos = 0;
      push_block(8'hA0);
      for (int k = 0; k < 16; k++) feed(8'hA0 + 8'(k), st);
      in_valid = 1'b0;
      drain(16);
      tick();
      tick();
      chk("fl_idle", out_valid_f, 0);
      chk("fl_qempty", qf.size(), 0);

      // Async reset during the 9th output byte.
      n_out = 0;
      push_block(8'hB0);
      for (int k = 0; k < 16; k++) feed(8'hB0 + 8'(k), st);
      in_valid = 1'b0;
      drain(8);
      chk("ar_pre_valid", out_valid_f, 1);
      chk("ar_pre_data", out_data_f, 8'hB8);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", out_valid_f, 0);
      chk("ar_last", out_last_f, 0);
      chk("ar_data", out_data_f, 8'h00);
      chk("ar_ready", in_ready_f, 1);
      chk("ar_valid_i", out_valid_i, 0);
      qf.delete();
      qi.delete();
      pos = 0;
      #3 rst_n = 1'b1;
      @(posedge clk);
      #1;
      n_out = 0;
      push_block(8'hC0);
      for (int k = 0; k < 16; k++) feed(8'hC0 + 8'(k), st);
      in_valid = 1'b0;
      drain(16);
      chk("ar_qempty", qf.size(), 0);
      chk("ar_idle", out_valid_f, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
